// File: rtl/lamp_pkg.sv
// Shared constants for the lamp driver blocks: channel geometry, PWM word depth
// and the DM633 shifter state encoding.
package lamp_pkg;

  localparam int c_ch_per_board = 32;
  localparam int c_bps          = 12;

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_fetch = 3'd1;
  localparam logic [2:0] c_st_load  = 3'd2;
  localparam logic [2:0] c_st_shift = 3'd3;
  localparam logic [2:0] c_st_latch = 3'd4;
  localparam logic [2:0] c_st_done  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = c_st_idle,
    FETCH = c_st_fetch,
    LOAD  = c_st_load,
    SHIFT = c_st_shift,
    LATCH = c_st_latch,
    DONE  = c_st_done
  } shifter_state_t;

endpackage

// File: rtl/dm633_gck_gen.sv
// DM633 grayscale clock divider: free-running square wave that toggles every
// c_gck_div clock cycles and starts low out of reset. Only instantiated when
// DM633_GCK_EN is defined.
module dm633_gck_gen #(
  parameter int c_gck_div = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic gck
);

  localparam int c_cnt_w = (c_gck_div > 1) ? $clog2(c_gck_div) : 1;

  logic [c_cnt_w-1:0] cnt;

  // divide counter; flip the output each time it reaches the terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      gck <= 1'b0;
    end else if (cnt == c_cnt_w'(c_gck_div - 1)) begin
      cnt <= '0;
      gck <= ~gck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dm633_shifter.sv
// DM633 frame read-out engine. On i_start it fetches every channel word from the
// framebuffer (highest address first), shifts each word MSB-first onto DAI/DCK,
// then pulses LAT to latch the frame. All pin outputs are registered so the
// driver lines never glitch on state decode.
// Optional build macro: DM633_GCK_EN enables the free-running GCK divider;
// without it o_gck is tied low.
//
// state | meaning
// IDLE  | waiting for i_start
// FETCH | o_ren high, o_raddr = current word index
// LOAD  | framebuffer data captured into the shift register
// SHIFT | serialising the word, 2*c_div clocks per bit
// LATCH | o_lat high for c_lat clocks
// DONE  | one-cycle o_done pulse, then back to IDLE
module dm633_shifter
  import lamp_pkg::*;
#(
  parameter  int c_ledboards = 30,
  parameter  int c_div       = 2,
  parameter  int c_lat       = 4,
  parameter  int c_gck_div   = 1,
  localparam int c_channels  = c_ledboards * c_ch_per_board,
  localparam int c_addr_w    = $clog2(c_channels)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  output logic                o_ren,
  output logic [c_addr_w-1:0] o_raddr,
  input  logic [c_bps-1:0]    i_rdata,
  output logic                o_dai,
  output logic                o_dck,
  output logic                o_lat,
  output logic                o_gck,
  output logic                o_busy,
  output logic                o_done
);

  localparam int c_ph_w  = $clog2(2 * c_div);
  localparam int c_bit_w = $clog2(c_bps);
  localparam int c_lat_w = (c_lat > 1) ? $clog2(c_lat) : 1;

  shifter_state_t state, state_nxt;

  logic [c_addr_w-1:0] idx, idx_nxt;
  logic [c_ph_w-1:0]   phase, phase_nxt;
  logic [c_bit_w-1:0]  bit_cnt, bit_nxt;
  logic [c_lat_w-1:0]  lat_cnt, lat_nxt;
  // holds the bits still to be sent; the bit on the wire lives in dai_q
  logic [c_bps-2:0]    shreg, shreg_nxt;
  logic                dai_q, dai_nxt;
  logic                dck_q, dck_nxt;
  logic                lat_q, ren_q, busy_q, done_q;

  // state, counters, shift register and registered pin outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      phase   <= '0;
      bit_cnt <= '0;
      lat_cnt <= '0;
      shreg   <= '0;
      dai_q   <= 1'b0;
      dck_q   <= 1'b0;
      lat_q   <= 1'b0;
      ren_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      phase   <= phase_nxt;
      bit_cnt <= bit_nxt;
      lat_cnt <= lat_nxt;
      shreg   <= shreg_nxt;
      dai_q   <= dai_nxt;
      dck_q   <= dck_nxt;
      lat_q   <= (state_nxt == LATCH);
      ren_q   <= (state_nxt == FETCH);
      busy_q  <= (state_nxt != IDLE);
      done_q  <= (state_nxt == DONE);
    end
  end

  // next-state, counter and serial data decisions
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    phase_nxt = phase;
    bit_nxt   = bit_cnt;
    lat_nxt   = lat_cnt;
    shreg_nxt = shreg;
    dai_nxt   = dai_q;

    case (state)
      IDLE: begin
        if (i_start) begin
          idx_nxt   = c_addr_w'(c_channels - 1);
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        state_nxt = LOAD;
      end
      LOAD: begin
        shreg_nxt = i_rdata[c_bps-2:0];
        dai_nxt   = i_rdata[c_bps-1];
        bit_nxt   = c_bit_w'(c_bps - 1);
        phase_nxt = '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (phase == c_ph_w'(2 * c_div - 1)) begin
          phase_nxt = '0;
          if (bit_cnt == '0) begin
            if (idx == '0) begin
              dai_nxt   = 1'b0;
              lat_nxt   = c_lat_w'(c_lat - 1);
              state_nxt = LATCH;
            end else begin
              idx_nxt   = idx - 1'b1;
              state_nxt = FETCH;
            end
          end else begin
            bit_nxt   = bit_cnt - 1'b1;
            dai_nxt   = shreg[c_bps-2];
            shreg_nxt = {shreg[c_bps-3:0], 1'b0};
          end
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      LATCH: begin
        dai_nxt = 1'b0;
        if (lat_cnt == '0) begin
          state_nxt = DONE;
        end else begin
          lat_nxt = lat_cnt - 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // DCK is high in the second half of every bit period
    dck_nxt = (state_nxt == SHIFT) && (phase_nxt >= c_ph_w'(c_div));
  end

  assign o_ren   = ren_q;
  assign o_raddr = idx;
  assign o_dai   = dai_q;
  assign o_dck   = dck_q;
  assign o_lat   = lat_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

`ifdef DM633_GCK_EN
  dm633_gck_gen #(
    .c_gck_div (c_gck_div)
  ) u_gck_gen (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .gck   (o_gck)
  );
`else
  assign o_gck = 1'b0;
`endif

endmodule

// File: tb/tb_dm633_shifter.sv
// Bench for dm633_shifter with one ledboard (32 channels), c_div=2, c_lat=4.
// A small framebuffer model answers reads; a scoreboard holds the expected
// address order, DAI bit stream and frame length for every started frame.
module tb_dm633_shifter;
  import lamp_pkg::*;

  localparam int c_ledboards = 1;
  localparam int c_div       = 2;
  localparam int c_lat       = 4;
  localparam int c_gck_div   = 1;
  localparam int c_channels  = c_ledboards * c_ch_per_board;
  localparam int c_addr_w    = $clog2(c_channels);
  localparam int c_frame_len = c_channels * (2 + c_bps * 2 * c_div) + c_lat + 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                ren;
  logic [c_addr_w-1:0] raddr;
  logic [c_bps-1:0]    rdata = '0;
  logic                dai, dck, lat, gck, busy, done;

  logic [c_bps-1:0] mem [c_channels];

  bit exp_bits[$];
  int exp_addr[$];
  int exp_len[$];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  dm633_shifter #(
    .c_ledboards (c_ledboards),
    .c_div       (c_div),
    .c_lat       (c_lat),
    .c_gck_div   (c_gck_div)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .o_ren   (ren),
    .o_raddr (raddr),
    .i_rdata (rdata),
    .o_dai   (dai),
    .o_dck   (dck),
    .o_lat   (lat),
    .o_gck   (gck),
    .o_busy  (busy),
    .o_done  (done)
  );

  // framebuffer read port: data one cycle after the enable
  always @(posedge clk) if (ren) rdata <= mem[raddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // expected response of one frame, straight from the read-out order rules
  task automatic issue_frame();
    for (int a = c_channels - 1; a >= 0; a--) begin
      exp_addr.push_back(a);
      for (int b = c_bps - 1; b >= 0; b--) exp_bits.push_back(mem[a][b]);
    end
    exp_len.push_back(c_frame_len);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (k < budget) begin
      @(negedge clk);
      if (done) break;
      k++;
    end
    if (k >= budget) check("done_timeout", 0, 1);
  endtask

  // monitor / scoreboard consumer
  bit armed = 0, prev_dck = 0, prev_gck = 0, after_done = 0;
  int busy_cnt = 0, lat_cnt = 0, rises = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      armed = 0; prev_dck = 0; prev_gck = 0; after_done = 0;
      busy_cnt = 0; lat_cnt = 0; rises = 0;
    end else if (!armed) begin
      armed = 1; prev_dck = dck; prev_gck = gck;
    end else begin
`ifdef DM633_GCK_EN
      check("gck_toggle", gck, !prev_gck);
`else
      check("gck_tied_low", gck, 0);
`endif
      prev_gck = gck;
      if (dck && !prev_dck) begin
        rises++;
        if (exp_bits.size() == 0) check("dck_extra_rise", 1, 0);
        else check("dai_bit", dai, exp_bits.pop_front());
      end
      if (lat) begin
        if (lat_cnt == 0) begin
          check("lat_after_last_dck_fall", prev_dck, 1);
          check("dck_rises_before_lat", rises, c_channels * c_bps);
        end
        lat_cnt++;
        check("dck_dai_low_in_lat", {dck, dai}, 0);
      end
      prev_dck = dck;
      if (ren) begin
        if (exp_addr.size() == 0) check("ren_unexpected", 1, 0);
        else check("raddr", raddr, exp_addr.pop_front());
      end
      if (busy) busy_cnt++;
      if (after_done) begin
        check("busy_after_done", busy, 0);
        after_done = 0;
      end
      if (done) begin
        check("busy_in_done", busy, 1);
        if (exp_len.size() == 0) check("done_unexpected", 1, 0);
        else check("frame_len", busy_cnt, exp_len.pop_front());
        check("lat_cycles", lat_cnt, c_lat);
        check("bits_left", exp_bits.size(), 0);
        busy_cnt = 0; lat_cnt = 0; rises = 0;
        after_done = 1;
        done_cnt++;
      end
    end
  end

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int k;
    int done_before;

    // reset held: start toggling must not wake anything up
    for (int i = 0; i < c_channels; i++) mem[i] = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = ~start;
      #1 check("reset_outputs", {ren, raddr, dai, dck, lat, gck, busy, done}, 0);
    end
    start = 1'b0;
    release_reset();

    // directed frame: only the top word carries data
    mem[c_channels-1] = 12'hA5C;
    issue_frame();
    wait_done(3 * c_frame_len);
    repeat (5) @(negedge clk);

    // random frame with start pulses mid-SHIFT and in the DONE cycle
    for (int i = 0; i < c_channels; i++) mem[i] = c_bps'($urandom);
    done_before = done_cnt;
    issue_frame();
    repeat (325) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3 * c_frame_len);
    if (done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    repeat (200) @(negedge clk);
    check("single_frame_per_start", done_cnt - done_before, 1);
    check("idle_after_ignored_starts", busy, 0);

    // reset during word 10 of a random frame
    for (int i = 0; i < c_channels; i++) mem[i] = c_bps'($urandom);
    done_before = done_cnt;
    issue_frame();
    k = 0;
    while (k < 3 * c_frame_len) begin
      @(negedge clk);
      if (ren && raddr == c_addr_w'(c_channels - 1 - 10)) break;
      k++;
    end
    if (k >= 3 * c_frame_len) check("word10_timeout", 0, 1);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {ren, raddr, dai, dck, lat, gck, busy, done}, 0);
    exp_bits.delete();
    exp_addr.delete();
    exp_len.delete();
    repeat (4) @(negedge clk);
    check("no_latch_on_abort", done_cnt - done_before, 0);
    release_reset();

    // fresh frame after the abort must restart from the top address
    for (int i = 0; i < c_channels; i++) mem[i] = c_bps'($urandom);
    issue_frame();
    wait_done(3 * c_frame_len);
    repeat (5) @(negedge clk);
    check("frames_completed_after_restart", done_cnt - done_before, 1);
    check("addr_queue_drained", exp_addr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
